// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bundle: instruction-RAM address/data plus the decode handshake.
// The fetch unit uses the master modport; the CPU/RAM side uses slave.
interface instr_fetch_unit_if;
  logic        clk_enable;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] instr_readdata;
  logic [31:0] instr_address;
  logic [31:0] instr_word;
  logic [31:0] pc_plus8;
  logic        in_delay_slot;
  logic        active;
  logic        fault;

  modport master (
    input  clk_enable,
    input  redirect_valid,
    input  redirect_target,
    input  instr_readdata,
    output instr_address,
    output instr_word,
    output pc_plus8,
    output in_delay_slot,
    output active,
    output fault
  );

  modport slave (
    output clk_enable,
    output redirect_valid,
    output redirect_target,
    output instr_readdata,
    input  instr_address,
    input  instr_word,
    input  pc_plus8,
    input  in_delay_slot,
    input  active,
    input  fault
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Program-counter owner for a combinational-read instruction RAM, with MIPS
// branch-delay-slot sequencing, halt-on-jump-to-HALT_ADDR and misaligned-target faulting.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic               clk,
  input  logic               reset,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DELAY  = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic [31:0] pending;
  logic [31:0] pending_nxt;
  logic [31:0] pc_inc;
  logic        running;

  assign pc_inc  = pc + 32'd4;
  assign running = (state == RUN) || (state == DELAY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      pc      <= RESET_VECTOR;
      pending <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      pending <= pending_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    pending_nxt = pending;
    if (bus.clk_enable) begin
      unique case (state)
        RUN: begin
          // Sequential wrap onto HALT_ADDR halts before that address is ever fetched,
          // even if a redirect arrives on the same edge.
          if (pc_inc == HALT_ADDR) begin
            state_nxt = HALTED;
            pc_nxt    = HALT_ADDR;
          end else begin
            pc_nxt = pc_inc;
            if (bus.redirect_valid) begin
              pending_nxt = bus.redirect_target;
              state_nxt   = DELAY;
            end
          end
        end
        DELAY: begin
          // A branch sitting in the delay slot is ignored; only the pending target matters.
          if (pending == HALT_ADDR) begin
            state_nxt = HALTED;
            pc_nxt    = HALT_ADDR;
          end else if (pending[1:0] != 2'b00) begin
            state_nxt = FAULT;
          end else begin
            state_nxt = RUN;
            pc_nxt    = pending;
          end
        end
        default: begin
          state_nxt = state;
        end
      endcase
    end
  end

  assign bus.instr_address = pc;
  assign bus.pc_plus8      = pc + 32'd8;
  assign bus.in_delay_slot = (state == DELAY);
  assign bus.active        = running;
  assign bus.fault         = (state == FAULT);
  assign bus.instr_word    = running ? bus.instr_readdata : 32'h0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal expectations, then
// randomized redirects/stalls/resets checked every cycle against a queue-based model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RV = 32'hBFC00000;
  localparam logic [31:0] HA = 32'h00000000;

  logic clk;
  logic reset;
  instr_fetch_unit_if ifc ();

  instr_fetch_unit #(.RESET_VECTOR(RV), .HALT_ADDR(HA)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h13572468;
  endfunction

  assign ifc.instr_readdata = mem_word(ifc.instr_address);

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  // Model: fetch address, queue of taken-branch targets awaiting their delay slot,
  // and a run mode (0 running, 1 halted, 2 faulted).
  logic [31:0] m_pc;
  logic [31:0] m_jq[$];
  int          m_mode;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RV;
    m_jq.delete();
    m_mode = 0;
  endtask

  task automatic model_edge(input bit ce, input bit rv, input logic [31:0] tgt);
    logic [31:0] t;
    if (reset || !ce || m_mode != 0) return;
    if (m_jq.size() != 0) begin
      t = m_jq.pop_front();
      if (t == HA) begin
        m_mode = 1;
        m_pc   = HA;
      end else if (t % 4 != 0) begin
        m_mode = 2;
      end else begin
        m_pc = t;
      end
    end else if (m_pc + 32'd4 == HA) begin
      m_mode = 1;
      m_pc   = HA;
    end else begin
      m_pc = m_pc + 32'd4;
      if (rv) m_jq.push_back(tgt);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("instr_address", ifc.instr_address, m_pc);
      chk("pc_plus8", ifc.pc_plus8, m_pc + 32'd8);
      chk("in_delay_slot", {31'd0, ifc.in_delay_slot}, {31'd0, (m_jq.size() != 0)});
      chk("active", {31'd0, ifc.active}, {31'd0, (m_mode == 0)});
      chk("fault", {31'd0, ifc.fault}, {31'd0, (m_mode == 2)});
      chk("instr_word", ifc.instr_word, (m_mode == 0) ? mem_word(m_pc) : 32'h0);
    end
  end

  task automatic cyc(input bit ce, input bit rv, input logic [31:0] tgt);
    ifc.clk_enable      = ce;
    ifc.redirect_valid  = rv;
    ifc.redirect_target = tgt;
    @(posedge clk);
    model_edge(ce, rv, tgt);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] tgt;
    reset               = 1'b1;
    ifc.clk_enable      = 1'b0;
    ifc.redirect_valid  = 1'b0;
    ifc.redirect_target = 32'h0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_en = 1'b1;

    // Reset state and sequential fetch
    chk("rst_addr", ifc.instr_address, 32'hBFC00000);
    chk("rst_plus8", ifc.pc_plus8, 32'hBFC00008);
    chk("rst_active", {31'd0, ifc.active}, 32'd1);
    chk("rst_slot", {31'd0, ifc.in_delay_slot}, 32'd0);
    cyc(1, 0, 0);
    chk("seq_addr1", ifc.instr_address, 32'hBFC00004);
    cyc(1, 1, 32'h20000000);
    chk("br_slot_addr", ifc.instr_address, 32'hBFC00008);
    chk("br_slot_flag", {31'd0, ifc.in_delay_slot}, 32'd1);
    cyc(1, 0, 0);
    chk("br_tgt_addr", ifc.instr_address, 32'h20000000);
    chk("br_tgt_flag", {31'd0, ifc.in_delay_slot}, 32'd0);

    // Jump to address 0 halts after the delay slot
    do_reset();
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("halt_pre_addr", ifc.instr_address, 32'hBFC0000C);
    cyc(1, 1, 32'h00000000);
    chk("halt_slot_addr", ifc.instr_address, 32'hBFC00010);
    chk("halt_slot_act", {31'd0, ifc.active}, 32'd1);
    cyc(1, 0, 0);
    chk("halt_active", {31'd0, ifc.active}, 32'd0);
    chk("halt_word", ifc.instr_word, 32'h0);
    for (int i = 0; i < 10; i++) cyc(1, i[0], 32'h00000400);
    chk("halt_stay", {31'd0, ifc.active}, 32'd0);

    // Misaligned target faults with the PC frozen on the delay slot
    do_reset();
    cyc(1, 1, 32'h20000002);
    chk("flt_slot_addr", ifc.instr_address, 32'hBFC00004);
    cyc(1, 0, 0);
    chk("flt_fault", {31'd0, ifc.fault}, 32'd1);
    chk("flt_active", {31'd0, ifc.active}, 32'd0);
    chk("flt_addr", ifc.instr_address, 32'hBFC00004);
    cyc(1, 1, 32'h100);
    chk("flt_stay", ifc.instr_address, 32'hBFC00004);

    // Stall held in DELAY
    do_reset();
    cyc(1, 1, 32'h30000000);
    for (int i = 0; i < 4; i++) begin
      cyc(0, i[0], 32'h40000000);
      chk("stall_addr", ifc.instr_address, 32'hBFC00004);
      chk("stall_slot", {31'd0, ifc.in_delay_slot}, 32'd1);
    end
    cyc(1, 0, 0);
    chk("stall_tgt", ifc.instr_address, 32'h30000000);

    // Asynchronous reset between edges while in DELAY
    do_reset();
    cyc(1, 1, 32'h1FFE0004);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_addr", ifc.instr_address, 32'hBFC00000);
    chk("arst_slot", {31'd0, ifc.in_delay_slot}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(1, 0, 0);
    chk("arst_seq1", ifc.instr_address, 32'hBFC00004);
    cyc(1, 0, 0);
    chk("arst_seq2", ifc.instr_address, 32'hBFC00008);

    // Randomized redirects, stalls and periodic resets
    for (int n = 0; n < 3000; n++) begin
      if (n % 120 == 119) begin
        do_reset();
      end else begin
        r = $urandom();
        case ($urandom_range(0, 9))
          0:       tgt = 32'h00000000;
          1:       tgt = {r[31:2], 2'b01 + r[1]};
          2:       tgt = 32'hFFFFFFF0 + {28'd0, r[3:2], 2'b00};
          default: tgt = {r[31:2], 2'b00};
        endcase
        cyc($urandom_range(0, 4) != 0, $urandom_range(0, 3) == 0, tgt);
      end
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
